// File: rtl/pc_pkg.sv
// pc_pkg: shared definitions for the program-counter slice.
//   PC_ADDR_W     : default PC / address width
//   PC_RESET_ADDR : default PC value loaded on reset
//   sel_t         : next-PC source chosen by the per-edge priority logic
package pc_pkg;

  localparam int unsigned     PC_ADDR_W     = 32;
  localparam longint unsigned PC_RESET_ADDR = 0;

  typedef enum logic [2:0] {
    SEL_HOLD      = 3'd0,  // stalled: everything holds
    SEL_SEQ       = 3'd1,  // pc + STEP
    SEL_JUMP      = 3'd2,  // relative or absolute jump
    SEL_CALL      = 3'd3,  // push return address, then jump
    SEL_RET       = 3'd4,  // pop RAS top into the PC
    SEL_RET_EMPTY = 3'd5   // return with empty RAS: sequential step + underflow
  } sel_t;

endpackage

// File: rtl/pc_ras_stack.sv
// ras_stack: circular return-address stack.
//   clk, reset      : clock and asynchronous active-high reset (pointer/count only)
//   push, push_data : write push_data as the new top; when full, the oldest
//                     entry is overwritten and the count saturates at DEPTH
//   pop             : discard the top entry (caller guarantees not empty)
//   top_data        : current top entry
//   count           : number of valid entries (0..DEPTH)
//   full, empty     : count == DEPTH / count == 0
module ras_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               top_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_ptr;    // next free slot; top lives at r_ptr-1
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_top_idx;

  // With a power-of-2 depth the slot after the newest is also the oldest,
  // so a push into a full stack naturally overwrites the oldest entry.
  assign w_top_idx = r_ptr - PW'(1);
  assign top_data  = r_mem[w_top_idx];
  assign count     = r_count;
  assign full      = (r_count == CW'(DEPTH));
  assign empty     = (r_count == '0);

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
    end else if (push) begin
      r_ptr <= r_ptr + PW'(1);
      if (!full) begin
        r_count <= r_count + CW'(1);
      end
    end else if (pop) begin
      r_ptr   <= r_ptr - PW'(1);
      r_count <= r_count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_unit.sv
// pc_unit: fetch-stage program counter with stall, jumps and call/return.
//   clk, reset         : clock and asynchronous active-high reset
//   stall              : freeze PC, RAS and redirect; requests are dropped
//   jump_en/jump_abs   : jump; absolute target or offset added to the PC
//   jump_target        : target or two's-complement offset (also used by call)
//   call_en, ret_en    : push pc+STEP and jump / pop RAS top into the PC
//   flag_clr           : clear sticky flags (a same-cycle set wins)
//   addr, redirect     : registered PC and "addr is non-sequential" marker
//   ras_count          : valid RAS entries
//   ras_overflow/underflow : sticky RAS error flags
module pc_unit
  import pc_pkg::*;
#(
  parameter int unsigned        ADDR_W     = PC_ADDR_W,
  parameter int unsigned        STEP       = 1,
  parameter logic [ADDR_W-1:0]  RESET_ADDR = ADDR_W'(PC_RESET_ADDR),
  parameter int unsigned        RAS_DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         jump_en,
  input  logic                         jump_abs,
  input  logic [ADDR_W-1:0]            jump_target,
  input  logic                         call_en,
  input  logic                         ret_en,
  input  logic                         flag_clr,
  output logic [ADDR_W-1:0]            addr,
  output logic                         redirect,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  logic [ADDR_W-1:0] r_pc;
  logic              r_redirect;
  logic              r_ovf;
  logic              r_unf;

  sel_t              w_sel;
  logic [ADDR_W-1:0] w_seq_pc;
  logic [ADDR_W-1:0] w_jump_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic              w_redirect_next;
  logic [ADDR_W-1:0] w_ras_top;
  logic              w_ras_full;
  logic              w_ras_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_ovf_set;
  logic              w_unf_set;

  // Modulo-2^ADDR_W arithmetic; a negative offset is just a wrapped add.
  assign w_seq_pc  = r_pc + ADDR_W'(STEP);
  assign w_jump_pc = jump_abs ? jump_target : (r_pc + jump_target);

  ras_stack #(
    .DEPTH (RAS_DEPTH),
    .W     (ADDR_W)
  ) u_ras (
    .clk       (clk),
    .reset     (reset),
    .push      (w_push),
    .push_data (w_seq_pc),
    .pop       (w_pop),
    .top_data  (w_ras_top),
    .count     (ras_count),
    .full      (w_ras_full),
    .empty     (w_ras_empty)
  );

  // Priority: stall > ret > call > jump > sequential. A simultaneous
  // call is dropped behind ret, so nothing is pushed and no flag is set.
  always_comb begin
    w_sel = SEL_SEQ;
    if (stall) begin
      w_sel = SEL_HOLD;
    end else if (ret_en) begin
      w_sel = w_ras_empty ? SEL_RET_EMPTY : SEL_RET;
    end else if (call_en) begin
      w_sel = SEL_CALL;
    end else if (jump_en) begin
      w_sel = SEL_JUMP;
    end
  end

  always_comb begin
    w_pc_next       = w_seq_pc;
    w_redirect_next = 1'b0;
    unique case (w_sel)
      SEL_HOLD: begin
        w_pc_next       = r_pc;
        w_redirect_next = r_redirect;
      end
      SEL_JUMP, SEL_CALL: begin
        w_pc_next       = w_jump_pc;
        w_redirect_next = 1'b1;
      end
      SEL_RET: begin
        w_pc_next       = w_ras_top;
        w_redirect_next = 1'b1;
      end
      default: begin
        w_pc_next       = w_seq_pc;
        w_redirect_next = 1'b0;
      end
    endcase
  end

  assign w_push    = (w_sel == SEL_CALL);
  assign w_pop     = (w_sel == SEL_RET);
  assign w_ovf_set = w_push && w_ras_full;
  assign w_unf_set = (w_sel == SEL_RET_EMPTY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc       <= RESET_ADDR;
      r_redirect <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_pc       <= w_pc_next;
      r_redirect <= w_redirect_next;
      // A set event in the same cycle as flag_clr wins.
      if (w_ovf_set) begin
        r_ovf <= 1'b1;
      end else if (flag_clr) begin
        r_ovf <= 1'b0;
      end
      if (w_unf_set) begin
        r_unf <= 1'b1;
      end else if (flag_clr) begin
        r_unf <= 1'b0;
      end
    end
  end

  assign addr          = r_pc;
  assign redirect      = r_redirect;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;

endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vector table, hand-written reset sequence and a
// randomized run against a queue-based reference model of pc_unit.
module tb_pc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, jump_en, jump_abs, call_en, ret_en, flag_clr;
  logic [31:0] jump_target;
  logic [31:0] addr;
  logic        redirect;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int checks = 0;
  int errors = 0;

  pc_unit #(
    .ADDR_W     (32),
    .STEP       (1),
    .RESET_ADDR (32'h0),
    .RAS_DEPTH  (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .jump_en       (jump_en),
    .jump_abs      (jump_abs),
    .jump_target   (jump_target),
    .call_en       (call_en),
    .ret_en        (ret_en),
    .flag_clr      (flag_clr),
    .addr          (addr),
    .redirect      (redirect),
    .ras_count     (ras_count),
    .ras_overflow  (ras_overflow),
    .ras_underflow (ras_underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic        st, je, ja;
    logic [31:0] tg;
    logic        ce, re, fc;
    logic [31:0] ea;
    logic        er;
    logic [2:0]  ec;
    logic        eo, eu;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic st, logic je, logic ja, logic [31:0] tg,
                              logic ce, logic re, logic fc,
                              logic [31:0] ea, logic er, logic [2:0] ec,
                              logic eo, logic eu);
    vec_t v;
    v.st = st; v.je = je; v.ja = ja; v.tg = tg; v.ce = ce; v.re = re; v.fc = fc;
    v.ea = ea; v.er = er; v.ec = ec; v.eo = eo; v.eu = eu;
    return v;
  endfunction

  task automatic drive(logic st, logic je, logic ja, logic [31:0] tg,
                       logic ce, logic re, logic fc);
    stall = st; jump_en = je; jump_abs = ja; jump_target = tg;
    call_en = ce; ret_en = re; flag_clr = fc;
  endtask

  task automatic check(string name, logic [31:0] ea, logic er, logic [2:0] ec,
                       logic eo, logic eu);
    checks++;
    if (addr !== ea || redirect !== er || ras_count !== ec ||
        ras_overflow !== eo || ras_underflow !== eu) begin
      errors++;
      $display("FAIL %s: got addr=%h red=%b cnt=%0d ovf=%b unf=%b, required addr=%h red=%b cnt=%0d ovf=%b unf=%b",
               name, addr, redirect, ras_count, ras_overflow, ras_underflow,
               ea, er, ec, eo, eu);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model state
  logic [31:0] m_pc;
  logic        m_red, m_ovf, m_unf;
  logic [31:0] m_ras[$];

  task automatic model_step(logic st, logic je, logic ja, logic [31:0] tg,
                            logic ce, logic re, logic fc);
    logic [31:0] dest;
    logic        oset, uset;
    oset = 1'b0;
    uset = 1'b0;
    dest = ja ? tg : m_pc + tg;
    if (!st) begin
      if (re) begin
        if (m_ras.size() > 0) begin
          m_pc  = m_ras.pop_back();
          m_red = 1'b1;
        end else begin
          m_pc  = m_pc + 32'd1;
          m_red = 1'b0;
          uset  = 1'b1;
        end
      end else if (ce) begin
        if (m_ras.size() == 4) begin
          void'(m_ras.pop_front());
          oset = 1'b1;
        end
        m_ras.push_back(m_pc + 32'd1);
        m_pc  = dest;
        m_red = 1'b1;
      end else if (je) begin
        m_pc  = dest;
        m_red = 1'b1;
      end else begin
        m_pc  = m_pc + 32'd1;
        m_red = 1'b0;
      end
    end
    if (fc) begin
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end
    if (oset) m_ovf = 1'b1;
    if (uset) m_unf = 1'b1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 32'h0, 0, 0, 0, 0);
    reset = 1'b0;

    // idle steps
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h1,0,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h2,0,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h3,0,0,0,0));
    // jumps
    vecs.push_back(mk(0,1,1,32'd10,0,0,0, 32'd10,1,0,0,0));
    vecs.push_back(mk(0,1,0,32'hFFFFFFFE,0,0,0, 32'd8,1,0,0,0));
    vecs.push_back(mk(0,1,1,32'h100,0,0,0, 32'h100,1,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h101,0,0,0,0));
    // call / steps / ret
    vecs.push_back(mk(0,1,1,32'd5,0,0,0, 32'd5,1,0,0,0));
    vecs.push_back(mk(0,0,1,32'h40,1,0,0, 32'h40,1,1,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h41,0,1,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h42,0,1,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd6,1,0,0,0));
    // five calls at pc 1..5, then five rets
    vecs.push_back(mk(0,1,1,32'd1,0,0,0, 32'd1,1,0,0,0));
    vecs.push_back(mk(0,0,1,32'd2,1,0,0, 32'd2,1,1,0,0));
    vecs.push_back(mk(0,0,1,32'd3,1,0,0, 32'd3,1,2,0,0));
    vecs.push_back(mk(0,0,1,32'd4,1,0,0, 32'd4,1,3,0,0));
    vecs.push_back(mk(0,0,1,32'd5,1,0,0, 32'd5,1,4,0,0));
    vecs.push_back(mk(0,0,1,32'd6,1,0,0, 32'd6,1,4,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd6,1,3,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd5,1,2,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd4,1,1,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd3,1,0,1,0));
    vecs.push_back(mk(0,0,0,32'h0,0,1,0, 32'd4,0,0,1,1));
    vecs.push_back(mk(0,0,0,32'h0,0,0,1, 32'd5,0,0,0,0));
    // stall with jump+call pending
    vecs.push_back(mk(0,0,1,32'h20,1,0,0, 32'h20,1,1,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h21,0,1,0,0));
    vecs.push_back(mk(1,1,1,32'h300,1,0,0, 32'h21,0,1,0,0));
    vecs.push_back(mk(1,1,1,32'h300,1,0,0, 32'h21,0,1,0,0));
    vecs.push_back(mk(1,1,1,32'h300,1,0,0, 32'h21,0,1,0,0));
    // call + ret together: pop only (top was pushed at pc 5)
    vecs.push_back(mk(0,0,1,32'h500,1,1,0, 32'd6,1,0,0,0));
    // underflow with flag_clr in same cycle: set wins
    vecs.push_back(mk(0,0,0,32'h0,0,1,1, 32'd7,0,0,0,1));
    // flag_clr acts during stall; stalled ret is dropped
    vecs.push_back(mk(1,0,0,32'h0,0,0,1, 32'd7,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0,0,1,0, 32'd7,0,0,0,0));
    // wrap at the top of the address space
    vecs.push_back(mk(0,1,1,32'hFFFFFFFF,0,0,0, 32'hFFFFFFFF,1,0,0,0));
    vecs.push_back(mk(0,0,0,32'h0,0,0,0, 32'h0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'h10,0,0,0, 32'h10,1,0,0,0));

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].je, vecs[i].ja, vecs[i].tg,
            vecs[i].ce, vecs[i].re, vecs[i].fc);
      tick();
      check($sformatf("vec%0d", i), vecs[i].ea, vecs[i].er, vecs[i].ec,
            vecs[i].eo, vecs[i].eu);
    end

    // Asynchronous reset in the middle of a stalled cycle
    drive(0, 0, 0, 0, 0, 1, 0);             // empty ret: sets underflow
    tick();
    check("pre_reset_unf", 32'h11, 0, 0, 0, 1);
    drive(0, 0, 1, 32'h0, 1, 0, 0);         // push something
    tick();
    drive(0, 1, 1, 32'h77, 0, 0, 0);
    tick();
    check("pre_reset_77", 32'h77, 1, 1, 0, 1);
    drive(1, 1, 1, 32'h300, 0, 0, 0);
    tick();
    check("stall_77", 32'h77, 1, 1, 0, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset_now", 32'h0, 0, 0, 0, 0);
    tick();
    check("reset_held_edge", 32'h0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
    check("reset_released", 32'h0, 0, 0, 0, 0);
    tick();
    check("resume_step", 32'h1, 0, 0, 0, 0);

    // Randomized run against the reference model
    reset = 1'b1;
    #1;
    reset = 1'b0;
    m_pc = 32'h0; m_red = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
    m_ras.delete();
    for (int n = 0; n < 400; n++) begin
      logic st, je, ja, ce, re, fc;
      logic [31:0] tg;
      st = ($urandom_range(7) == 0);
      je = ($urandom_range(3) == 0);
      ja = $urandom_range(1);
      ce = ($urandom_range(3) == 0);
      re = ($urandom_range(3) == 0);
      fc = ($urandom_range(9) == 0);
      case ($urandom_range(2))
        0:       tg = $urandom;
        1:       tg = 32'($urandom_range(64));
        default: tg = 32'hFFFFFFFF - 32'($urandom_range(16));
      endcase
      drive(st, je, ja, tg, ce, re, fc);
      model_step(st, je, ja, tg, ce, re, fc);
      tick();
      check($sformatf("rand%0d", n), m_pc, m_red, 3'(m_ras.size()), m_ovf, m_unf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
